// File: rtl/audio_frame_packer_if.sv
// Stream bundle for audio_frame_packer: mono sample input, stereo frame output, status.
// The slave modport is the packer's view; the master modport is the surrounding system's view.
interface audio_frame_packer_if #(
  parameter int unsigned LEVEL_W = 4
);
  logic               s_axis_tvalid;
  logic               s_axis_tready;
  logic [31:0]        s_axis_tdata;
  logic               s_axis_tlast;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [63:0]        m_axis_tdata;
  logic [LEVEL_W-1:0] fifo_level;
  logic               framing_error;
  logic [15:0]        underrun_count;

  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, fifo_level, framing_error,
           underrun_count
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, fifo_level, framing_error,
           underrun_count
  );
endinterface

// File: rtl/audio_frame_packer.sv
// Packs Left/Right mono samples into 64-bit stereo frames and buffers them in a FWFT FIFO.
// Define AUDIO_PACKER_STATS_EN to build the saturating underrun counter.
module audio_frame_packer #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned LEVEL_W    = 4
) (
  input logic                 ac_bclk,
  input logic                 reset,
  audio_frame_packer_if.slave bus
);
  localparam int unsigned AddrW = LEVEL_W - 1;
  localparam logic [LEVEL_W-1:0] PtrOne = 1;

  typedef enum logic [0:0] {ExpLeft, ExpRight} state_e;

  state_e             state_q, state_d;
  logic [31:0]        left_hold_q, left_hold_d;
  logic [LEVEL_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic               ferr_q, ferr_d;
  logic [63:0]        mem_q [FIFO_DEPTH];

  logic full, empty, s_fire, m_fire, wr_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign full  = (wptr_q[AddrW] != rptr_q[AddrW]) &&
                 (wptr_q[AddrW-1:0] == rptr_q[AddrW-1:0]);
  assign empty = (wptr_q == rptr_q);

  assign s_fire = bus.s_axis_tvalid && !full;
  assign m_fire = bus.m_axis_tready && !empty;

  always_comb begin
    state_d     = state_q;
    left_hold_d = left_hold_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    ferr_d      = 1'b0;
    wr_en       = 1'b0;
    if (s_fire) begin
      unique case (state_q)
        ExpLeft: begin
          if (!bus.s_axis_tlast) begin
            left_hold_d = bus.s_axis_tdata;
            state_d     = ExpRight;
          end else begin
            ferr_d = 1'b1;
          end
        end
        ExpRight: begin
          if (bus.s_axis_tlast) begin
            wr_en   = 1'b1;
            wptr_d  = wptr_q + PtrOne;
            state_d = ExpLeft;
          end else begin
            // A repeated Left replaces the stale one; the newest Left pairs with the next Right.
            left_hold_d = bus.s_axis_tdata;
            ferr_d      = 1'b1;
          end
        end
        default: state_d = ExpLeft;
      endcase
    end
    if (m_fire) begin
      rptr_d = rptr_q + PtrOne;
    end
  end

  always_ff @(posedge ac_bclk) begin
    if (reset) begin
      state_q     <= ExpLeft;
      left_hold_q <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      left_hold_q <= left_hold_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      ferr_q      <= ferr_d;
    end
  end

  always_ff @(posedge ac_bclk) begin
    if (wr_en) begin
      mem_q[wptr_q[AddrW-1:0]] <= {bus.s_axis_tdata, left_hold_q};
    end
  end

  assign bus.s_axis_tready = !full;
  assign bus.m_axis_tvalid = !empty;
  assign bus.m_axis_tdata  = empty ? 64'h0 : mem_q[rptr_q[AddrW-1:0]];
  assign bus.fifo_level    = wptr_q - rptr_q;
  assign bus.framing_error = ferr_q;

`ifdef AUDIO_PACKER_STATS_EN
  logic [15:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (bus.m_axis_tready && empty && (underrun_q != 16'hFFFF)) begin
      underrun_d = underrun_q + 16'd1;
    end
  end

  always_ff @(posedge ac_bclk) begin
    if (reset) begin
      underrun_q <= '0;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign bus.underrun_count = underrun_q;
`else
  assign bus.underrun_count = 16'h0;
`endif
endmodule

// File: tb/tb_audio_frame_packer.sv
// Self-checking bench for audio_frame_packer: directed table, corner sequences, random traffic
// compared each cycle against a queue-based frame model.
module tb_audio_frame_packer;
  localparam int unsigned Depth = 8;
  localparam int unsigned LevelW = 4;

  logic ac_bclk;
  logic reset;

  audio_frame_packer_if #(.LEVEL_W(LevelW)) bus ();

  audio_frame_packer #(
    .FIFO_DEPTH(Depth),
    .LEVEL_W   (LevelW)
  ) dut (
    .ac_bclk(ac_bclk),
    .reset  (reset),
    .bus    (bus)
  );

  initial begin
    ac_bclk = 1'b0;
    forever #5 ac_bclk = ~ac_bclk;
  end

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: frames in flight, pending Left, last-cycle error flag, underrun tally.
  logic [63:0] mq[$];
  bit          m_exp_right;
  logic [31:0] m_left;
  bit          m_err;
  int unsigned m_und;

  typedef struct {
    bit          rst;
    bit          sv;
    logic [31:0] sd;
    bit          sl;
    bit          mr;
    bit          e_valid;
    int unsigned e_level;
    logic [63:0] e_data;
    bit          e_ferr;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_model();
    logic [63:0] exp_data;
    exp_data = (mq.size() == 0) ? 64'h0 : mq[0];
    chk("s_axis_tready", 64'(bus.s_axis_tready), 64'(mq.size() < Depth));
    chk("m_axis_tvalid", 64'(bus.m_axis_tvalid), 64'(mq.size() != 0));
    chk("m_axis_tdata", bus.m_axis_tdata, exp_data);
    chk("fifo_level", 64'(bus.fifo_level), 64'(mq.size()));
    chk("framing_error", 64'(bus.framing_error), 64'(m_err));
`ifdef AUDIO_PACKER_STATS_EN
    chk("underrun_count", 64'(bus.underrun_count), 64'(m_und));
`else
    chk("underrun_count", 64'(bus.underrun_count), 64'h0);
`endif
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check #1 after it.
  task automatic cycle(input bit rst, input bit sv, input logic [31:0] sd, input bit sl,
                       input bit mr);
    int unsigned sz;
    bit sf;
    reset             = rst;
    bus.s_axis_tvalid = sv;
    bus.s_axis_tdata  = sd;
    bus.s_axis_tlast  = sl;
    bus.m_axis_tready = mr;
    sz = mq.size();
    @(posedge ac_bclk);
    if (rst) begin
      mq.delete();
      m_exp_right = 1'b0;
      m_left      = '0;
      m_err       = 1'b0;
      m_und       = 0;
    end else begin
      sf    = sv && (sz < Depth);
      m_err = 1'b0;
      if (mr && sz == 0 && m_und < 32'h0000_FFFF) m_und++;
      if (mr && sz != 0) void'(mq.pop_front());
      if (sf) begin
        if (!m_exp_right) begin
          if (!sl) begin
            m_left      = sd;
            m_exp_right = 1'b1;
          end else begin
            m_err = 1'b1;
          end
        end else if (sl) begin
          mq.push_back({sd, m_left});
          m_exp_right = 1'b0;
        end else begin
          m_left = sd;
          m_err  = 1'b1;
        end
      end
    end
    #1;
    check_model();
  endtask

  initial begin
    logic [31:0] d;
    bit sl, mr;
    int unsigned bias;

    // rst sv sd sl mr | valid level data ferr
    tbl[0]  = '{0, 1, 32'h0000_1111, 0, 0, 0, 0, 64'h0, 0};
    tbl[1]  = '{0, 1, 32'h0000_2222, 1, 0, 1, 1, 64'h0000_2222_0000_1111, 0};
    tbl[2]  = '{0, 0, 32'h0, 0, 1, 0, 0, 64'h0, 0};
    tbl[3]  = '{0, 1, 32'h0000_AAAA, 1, 0, 0, 0, 64'h0, 1};
    tbl[4]  = '{0, 0, 32'h0, 0, 0, 0, 0, 64'h0, 0};
    tbl[5]  = '{0, 1, 32'h0000_0001, 0, 0, 0, 0, 64'h0, 0};
    tbl[6]  = '{0, 1, 32'h0000_0002, 0, 0, 0, 0, 64'h0, 1};
    tbl[7]  = '{0, 1, 32'h0000_0003, 1, 0, 1, 1, 64'h0000_0003_0000_0002, 0};
    tbl[8]  = '{0, 0, 32'h0, 0, 1, 0, 0, 64'h0, 0};
    tbl[9]  = '{0, 1, 32'h0000_0055, 0, 0, 0, 0, 64'h0, 0};
    tbl[10] = '{1, 0, 32'h0, 0, 0, 0, 0, 64'h0, 0};
    tbl[11] = '{0, 1, 32'h0000_0066, 1, 0, 0, 0, 64'h0, 1};
    tbl[12] = '{0, 0, 32'h0, 0, 0, 0, 0, 64'h0, 0};

    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("reset_tready", 64'(bus.s_axis_tready), 64'h1);
    chk("reset_tvalid", 64'(bus.m_axis_tvalid), 64'h0);
    chk("reset_tdata", bus.m_axis_tdata, 64'h0);

    foreach (tbl[i]) begin
      cycle(tbl[i].rst, tbl[i].sv, tbl[i].sd, tbl[i].sl, tbl[i].mr);
      chk($sformatf("tbl%0d_valid", i), 64'(bus.m_axis_tvalid), 64'(tbl[i].e_valid));
      chk($sformatf("tbl%0d_level", i), 64'(bus.fifo_level), 64'(tbl[i].e_level));
      chk($sformatf("tbl%0d_data", i), bus.m_axis_tdata, tbl[i].e_data);
      chk($sformatf("tbl%0d_ferr", i), 64'(bus.framing_error), 64'(tbl[i].e_ferr));
    end

    // Fill to full with the reader stalled, then pop exactly one frame.
    cycle(1, 0, 0, 0, 0);
    for (int f = 0; f < Depth; f++) begin
      cycle(0, 1, 32'h100 + 32'(f), 0, 0);
      cycle(0, 1, 32'h200 + 32'(f), 1, 0);
    end
    chk("full_level", 64'(bus.fifo_level), 64'(Depth));
    chk("full_tready", 64'(bus.s_axis_tready), 64'h0);
    chk("full_head", bus.m_axis_tdata, 64'h0000_0200_0000_0100);
    cycle(0, 1, 32'hDEAD, 0, 0);
    chk("full_no_write", 64'(bus.fifo_level), 64'(Depth));
    cycle(0, 0, 0, 0, 1);
    chk("pop_level", 64'(bus.fifo_level), 64'(Depth - 1));
    chk("pop_tready", 64'(bus.s_axis_tready), 64'h1);
    chk("pop_next", bus.m_axis_tdata, 64'h0000_0201_0000_0101);

    // Underrun while empty.
    cycle(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 1);
`ifdef AUDIO_PACKER_STATS_EN
    chk("underrun5", 64'(bus.underrun_count), 64'd5);
`else
    chk("underrun5", 64'(bus.underrun_count), 64'd0);
`endif
    chk("underrun_data", bus.m_axis_tdata, 64'h0);

    // Simultaneous write and read at level 3.
    for (int f = 0; f < 3; f++) begin
      cycle(0, 1, 32'h300 + 32'(f), 0, 0);
      cycle(0, 1, 32'h400 + 32'(f), 1, 0);
    end
    cycle(0, 1, 32'h555, 0, 0);
    cycle(0, 1, 32'h666, 1, 1);
    chk("wr_rd_level", 64'(bus.fifo_level), 64'd3);
    chk("wr_rd_head", bus.m_axis_tdata, 64'h0000_0401_0000_0301);

    // Random traffic with occasional framing slips, stall phases and resets.
    bias = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 150 == 0) bias = $urandom_range(1, 4);
      d  = $urandom;
      sl = m_exp_right ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 7) == 0);
      mr = ($urandom_range(0, 4) < bias);
      cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 3) != 0), d, sl, mr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/audio_frame_packer.md
AUDIO_FRAME_PACKER -- requirements
Module: audio_frame_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of 64-bit stereo frames buffered; power of two, minimum 2.
REQ-002 SHALL have parameter LEVEL_W, default 4: width of fifo_level; equals log2(FIFO_DEPTH)+1.
REQ-003 SHALL have port ac_bclk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port s_axis_tvalid, input, 1 bit: upstream mono sample valid.
REQ-006 SHALL have port s_axis_tready, output, 1 bit: block accepts the sample.
REQ-007 SHALL have port s_axis_tdata, input, 32 bits: one channel sample.
REQ-008 SHALL have port s_axis_tlast, input, 1 bit: 0 = Left sample, 1 = Right sample.
REQ-009 SHALL have port m_axis_tvalid, output, 1 bit: stereo frame available to the serializer.
REQ-010 SHALL have port m_axis_tready, input, 1 bit: serializer consumes the frame.
REQ-011 SHALL have port m_axis_tdata, output, 64 bits: frame {Right[63:32], Left[31:0]}.
REQ-012 SHALL have port fifo_level, output, LEVEL_W bits: frames currently stored.
REQ-013 SHALL have port framing_error, output, 1 bit: one-cycle pulse on an out-of-order channel beat.
REQ-014 SHALL have port underrun_count, output, 16 bits: count of reads attempted while empty.

Function
REQ-015 SHALL define a transfer on either side as tvalid && tready in the same cycle.
REQ-016 SHALL implement a packer FSM with states EXP_LEFT and EXP_RIGHT; reset state EXP_LEFT.
REQ-017 In EXP_LEFT, a transfer with tlast=0 SHALL load the left holding register and go to EXP_RIGHT.
REQ-018 In EXP_LEFT, a transfer with tlast=1 SHALL be discarded, pulse framing_error, and stay in EXP_LEFT.
REQ-019 In EXP_RIGHT, a transfer with tlast=1 SHALL write {s_axis_tdata, left_hold} into the FIFO and go to EXP_LEFT.
REQ-020 In EXP_RIGHT, a transfer with tlast=0 SHALL overwrite left_hold, pulse framing_error, and stay in EXP_RIGHT.
REQ-021 SHALL drive s_axis_tready = ~fifo_full in both states.
REQ-022 SHALL present first-word-fall-through output: m_axis_tvalid = ~fifo_empty; m_axis_tdata = oldest frame, forced to 0 while empty.
REQ-023 SHALL have one-cycle latency: a frame written at edge N is valid on m_axis after edge N.
REQ-024 SHALL hold m_axis_tdata stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-025 SHALL use read and write pointers of LEVEL_W bits that wrap modulo 2*FIFO_DEPTH; full when the MSBs differ and the LSBs are equal; empty when the pointers are equal.
REQ-026 On a simultaneous write and read, fifo_level SHALL stay unchanged and both pointers SHALL advance.
REQ-027 When full, no write SHALL occur (tready=0); the held left sample SHALL be retained.
REQ-028 m_axis_tready=1 while empty SHALL be an underrun: no pointer change and no data corruption.

Reset
REQ-029 While reset=1 at an edge: FSM to EXP_LEFT, pointers and fifo_level to 0, left_hold to 0, framing_error to 0, underrun_count to 0.
REQ-030 After reset: s_axis_tready=1, m_axis_tvalid=0, m_axis_tdata=0.
REQ-031 Reset asserted mid-frame SHALL discard the held left sample and all buffered frames.
REQ-032 FIFO storage contents SHALL NOT need a reset.

Configuration
REQ-033 Macro AUDIO_PACKER_STATS_EN defined: underrun_count SHALL increment by 1 per underrun cycle and saturate at 16'hFFFF.
REQ-034 AUDIO_PACKER_STATS_EN undefined: underrun_count SHALL be constant 0 and its counter logic SHALL be omitted; all other behaviour is identical.

Verification
REQ-035 Send L=32'h0000_1111 (tlast=0), then R=32'h0000_2222 (tlast=1) -> the cycle after R, m_axis_tvalid=1, m_axis_tdata=64'h0000_2222_0000_1111, fifo_level=1.
REQ-036 Write 8 frames with m_axis_tready=0 -> fifo_level=8, s_axis_tready=0. Raise m_axis_tready for one cycle -> level 7, tready=1, the first frame is popped in order.
REQ-037 Send R first (tlast=1) -> framing_error pulses once, no write. Then send L, L' (both tlast=0), R -> one error pulse, and the written frame is {R, L'}.
REQ-038 With the FIFO empty, hold m_axis_tready=1 for 5 cycles -> underrun_count=5 with the macro, 0 without; m_axis_tdata=0.
REQ-039 Write and read in the same cycle at level 3 -> level stays 3. Wrap the pointers past 2*FIFO_DEPTH frames -> data order is preserved.
REQ-040 Assert reset after an accepted L, then send R (tlast=1) -> framing_error pulses, no frame is written, level is 0.
